ram_weight_loader: RTL
======================

Name: ram_weight_loader

Overview:
- Fetches one layer's weight set from the synchronous weight RAM and writes it into the neuron array's weight registers.
- Started by the network controller's one-cycle RAM-start pulse with the current layer_sel; returns a one-cycle ram_done pulse when every weight is written.
- Sits between the network controller and the weight RAM / neuron array.

Parameters:
- DATA_W, 16, weight word width.
- ADDR_W, 10, weight RAM address width.
- NUM_NEURONS, 8, neurons per layer.
- NUM_INPUTS, 8, weights per neuron.
- LAYER_STRIDE, 64, RAM words reserved per layer; must be >= NUM_NEURONS*NUM_INPUTS.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle load request (RAM-start pulse from the controller).
- layer_sel  in  2  layer to load; valid values are 0..2.
- ram_en  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en.
- wr_en  out  1  weight register write strobe.
- wr_neuron  out  clog2(NUM_NEURONS)  target neuron index.
- wr_input  out  clog2(NUM_INPUTS)  target weight index within the neuron.
- wr_data  out  DATA_W  weight value.
- busy  out  1  high from the cycle after start is accepted until ram_done.
- ram_done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with ram_done, on an invalid layer_sel.

Behaviour:
- Definitions: T = NUM_NEURONS*NUM_INPUTS. base = layer_sel*LAYER_STRIDE, computed at ADDR_W width.
- Reset: state IDLE. ram_en, wr_en, busy, ram_done, err = 0. ram_addr, wr_neuron, wr_input, wr_data = 0. All counters = 0.
- IDLE:
  - start=1 with layer_sel<=2: latch base, clear the read counter rc and write counter wc, go to READ.
  - start=1 with layer_sel==3: go to FAIL. No RAM access.
  - start=0: stay in IDLE.
- READ:
  - Each cycle: ram_en=1, ram_addr=base+rc, rc increments.
  - When rc reaches T-1, go to DRAIN on the following edge.
  - ram_en is high for exactly T consecutive cycles.
- Write pipeline (active in READ and DRAIN):
  - A registered valid flag follows ram_en by one cycle.
  - When the flag is high: wr_en=1, wr_data=ram_rdata, wr_neuron=wc/NUM_INPUTS, wr_input=wc%NUM_INPUTS, then wc increments.
  - Implement the division and modulo as a nested counter pair, not as dividers.
  - wr_en is high for exactly T consecutive cycles, starting one cycle after the first ram_en.
- DRAIN: ram_en=0; the last write completes here. Go to DONE.
- DONE: ram_done=1 for one cycle, busy=0, go to IDLE.
- FAIL: ram_done=1 and err=1 for one cycle, go to IDLE.
- Latency: start sampled at edge E0 gives first ram_en in cycle E0+1, last wr_en in cycle E0+T+1, ram_done in cycle E0+T+2.
- start while busy: ignored. No queuing, and the latched base is unchanged.
- start in the same cycle as ram_done: ignored, since the block is not yet in IDLE. The controller only re-issues start after ram_done.
- layer_sel changes mid-load: no effect; only the value latched at start is used.
- Reset mid-load: all outputs return to reset values on the next edge. No further wr_en. No ram_done.
- Outputs when idle: wr_neuron, wr_input and wr_data hold their last values while wr_en=0. ram_addr holds its last value while ram_en=0.
- Address wrap: base+rc is truncated to ADDR_W bits. Parameter legality guarantees the highest address, 2*LAYER_STRIDE+T-1, fits in ADDR_W bits.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [DATA_W-1:0].
  - checksum is cleared when start is accepted and accumulates wr_data modulo 2^DATA_W on every wr_en.
  - The value is stable from the ram_done cycle until the next accepted start. Reset clears it to 0.
- When undefined: no port and no accumulator logic; all other behaviour is identical.

Test Plan:
- Basic load: RAM word at address a holds a, layer_sel=1, start pulse -> ram_addr runs 64..127. 64 wr_en cycles with (neuron, input) stepping (0,0),(0,1)..(7,7) and wr_data = 64..127. ram_done exactly 66 cycles after the start edge; err=0.
- Layers 0 and 2: layer_sel=0 -> addresses 0..63. layer_sel=2 -> addresses 128..191. Each completes with one ram_done pulse.
- Invalid layer: layer_sel=3 with start -> ram_en never asserts, wr_en never asserts; ram_done=1 and err=1 in the cycle after start.
- Busy protection:
  - Extra start pulse at cycle 20 with layer_sel changed to 0 -> no restart; addresses continue on layer 1; one ram_done at cycle 66.
  - start asserted in the ram_done cycle -> ignored.
- Reset mid-load: reset at cycle 30 for one cycle -> next edge gives ram_en=0, wr_en=0, busy=0; no ram_done; a following start performs a full 64-word load.
- With LOADER_CHECKSUM_EN defined, basic load stimulus -> checksum = sum 64..127 = 6112 (0x17E0), valid at ram_done.

Source files
------------

// File: rtl/ram_weight_loader.sv
// ---------------------------------------------------------------------------
// ram_weight_loader
//
// Fetches one layer's weight set (NUM_NEURONS*NUM_INPUTS words) from the
// synchronous weight RAM and streams it into the neuron array's weight
// registers. A load is started by a one-cycle start pulse carrying
// layer_sel. Completion is signalled by a one-cycle ram_done pulse.
// layer_sel == 3 is rejected with ram_done + err and no RAM access.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   adds output checksum, the modulo-2^DATA_W sum of every weight written
//   during the most recent accepted load. It is stable from ram_done until
//   the next accepted start.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   one-cycle load request
//   layer_sel  in   layer to load (0..2 valid)
//   ram_en     out  RAM read enable
//   ram_addr   out  RAM read address (holds while ram_en=0)
//   ram_rdata  in   RAM read data, valid the cycle after ram_en
//   wr_en      out  weight register write strobe
//   wr_neuron  out  target neuron index (holds while wr_en=0)
//   wr_input   out  target weight index within neuron (holds while wr_en=0)
//   wr_data    out  weight value (holds while wr_en=0)
//   busy       out  load in progress
//   ram_done   out  one-cycle completion pulse
//   err        out  one-cycle pulse with ram_done on invalid layer_sel
//   checksum   out  (LOADER_CHECKSUM_EN only) sum of written weights
// ---------------------------------------------------------------------------
module ram_weight_loader #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int NUM_NEURONS  = 8,
    parameter int NUM_INPUTS   = 8,
    parameter int LAYER_STRIDE = 64,
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        layer_sel,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              wr_en,
    output logic [NW-1:0]     wr_neuron,
    output logic [IW-1:0]     wr_input,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              ram_done,
    output logic              err
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int T    = NUM_NEURONS * NUM_INPUTS;
    localparam int RC_W = $clog2(T + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   base_r;
    logic [RC_W-1:0]     rc_r;
    logic [NW-1:0]       nxt_neuron_r;
    logic [IW-1:0]       nxt_input_r;
    logic [DATA_W-1:0]   wr_data_hold_r;
    logic [ADDR_W-1:0]   base_s;
    logic                accept_s;
    logic                reject_s;

    // Layer base address, truncated to the RAM address width.
    assign base_s   = ADDR_W'(layer_sel) * ADDR_W'(LAYER_STRIDE);
    assign accept_s = (state_r == ST_IDLE) && start && (layer_sel != 2'd3);
    assign reject_s = (state_r == ST_IDLE) && start && (layer_sel == 2'd3);

    // Control FSM: read address sequencing, busy and completion pulses.
    // The first address is issued in the same edge that accepts start, so
    // rc_r starts at 1 and counts addresses already issued; when it reaches
    // T the read phase is over.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            base_r   <= '0;
            rc_r     <= '0;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            busy     <= 1'b0;
            ram_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ram_done <= 1'b0;
                    err      <= 1'b0;
                    if (accept_s) begin
                        state_r  <= ST_READ;
                        base_r   <= base_s;
                        ram_en   <= 1'b1;
                        ram_addr <= base_s;
                        rc_r     <= RC_W'(1);
                        busy     <= 1'b1;
                    end else if (reject_s) begin
                        state_r  <= ST_FAIL;
                        ram_done <= 1'b1;
                        err      <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (rc_r == RC_W'(T)) begin
                        ram_en  <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        ram_en   <= 1'b1;
                        ram_addr <= base_r + ADDR_W'(rc_r);
                        rc_r     <= rc_r + RC_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Last write strobe is on the bus during this cycle.
                    ram_done <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    ram_done <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                ST_FAIL: begin
                    ram_done <= 1'b0;
                    err      <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ram_en   <= 1'b0;
                    busy     <= 1'b0;
                    ram_done <= 1'b0;
                    err      <= 1'b0;
                end
            endcase
        end
    end

    // Write pipeline: wr_en is the valid flag trailing ram_en by one cycle.
    // The neuron/input target comes from a nested counter pair (input index
    // wraps into the neuron index); it is copied to the outputs one edge
    // ahead of each write so the outputs keep the last target afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en          <= 1'b0;
            wr_neuron      <= '0;
            wr_input       <= '0;
            nxt_neuron_r   <= '0;
            nxt_input_r    <= '0;
            wr_data_hold_r <= '0;
        end else begin
            wr_en <= ram_en;
            if (wr_en) begin
                wr_data_hold_r <= ram_rdata;
            end else begin
                wr_data_hold_r <= wr_data_hold_r;
            end
            if (accept_s) begin
                nxt_neuron_r <= '0;
                nxt_input_r  <= '0;
            end else if (ram_en) begin
                wr_neuron <= nxt_neuron_r;
                wr_input  <= nxt_input_r;
                if (nxt_input_r == IW'(NUM_INPUTS - 1)) begin
                    nxt_input_r  <= '0;
                    nxt_neuron_r <= nxt_neuron_r + NW'(1);
                end else begin
                    nxt_input_r  <= nxt_input_r + IW'(1);
                end
            end else begin
                nxt_neuron_r <= nxt_neuron_r;
                nxt_input_r  <= nxt_input_r;
            end
        end
    end

    // RAM data arrives in the same cycle as its write strobe, so wr_data
    // passes it straight through and otherwise shows the last written word.
    always_comb begin
        if (wr_en) begin
            wr_data = ram_rdata;
        end else begin
            wr_data = wr_data_hold_r;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running modulo sum of written weights, restarted on each accepted load.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept_s) begin
            checksum <= '0;
        end else if (wr_en) begin
            checksum <= checksum + ram_rdata;
        end else begin
            checksum <= checksum;
        end
    end
`endif

endmodule
